uart_rx_frame: RTL and testbench



---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_sampler.sv | 44 ++++
 rtl/uart_rx_frame.sv | 168 ++++++++++++++++
 tb/tb_uart_rx_frame.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: RX FSM state type, prescale constants and parity polarity.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_rx_state_e;

    localparam int unsigned PRESCALE_8       = 8;
    localparam int unsigned PRESCALE_16      = 16;
    localparam int unsigned PRESCALE_32      = 32;
    localparam int unsigned PRESCALE_DEFAULT = PRESCALE_16;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_sampler.sv
// RX line synchronizer plus 3-sample majority vote around the middle of each bit period.
module uart_rx_sampler #(
    parameter int unsigned PRESCALE_W  = 6,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rx_i,
    input  logic [PRESCALE_W-1:0] edge_cnt_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic                  rx_s_o,
    output logic                  sampled_bit_o,
    output logic                  sample_done_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [2:0]             smp_q, smp_d;
    logic [PRESCALE_W-1:0]  half;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '1;
            smp_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
            smp_q  <= smp_d;
        end
    end

    assign rx_s_o = sync_q[SYNC_STAGES-1];

    always_comb begin
        half  = prescale_i >> 1;
        smp_d = smp_q;
        if (edge_cnt_i == half - PRESCALE_W'(1)) smp_d[0] = rx_s_o;
        if (edge_cnt_i == half)                  smp_d[1] = rx_s_o;
        if (edge_cnt_i == half + PRESCALE_W'(1)) smp_d[2] = rx_s_o;
    end

    // The third sample lands in smp_q one cycle after it is taken, hence P/2+2.
    assign sampled_bit_o = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
    assign sample_done_o = (edge_cnt_i == half + PRESCALE_W'(2));

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive frame deserializer: start detect, LSB-first data, optional parity, stop check.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned PRESCALE_W  = 6,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_RX_IN,
    input  logic                  i_PAR_EN,
    input  logic                  i_PAR_TYP,
    input  logic [PRESCALE_W-1:0] i_Prescale,
    output logic [DATA_W-1:0]     o_P_DATA,
    output logic                  o_data_valid,
    output logic                  o_par_err,
    output logic                  o_stp_err
);

    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    uart_rx_state_e        state_q, state_d;
    logic [PRESCALE_W-1:0] edge_q, edge_d;
    logic [PRESCALE_W-1:0] p_q, p_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_W-1:0]     shift_q, shift_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;
    logic                  rx_prev_q;

    logic                  rx_s, sampled_bit, sample_done;
    logic                  edge_last, exp_par;
    logic [PRESCALE_W-1:0] presc_legal;

    uart_rx_sampler #(
        .PRESCALE_W (PRESCALE_W),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sampler (
        .clk_i        (i_clk),
        .rst_i        (i_rst),
        .rx_i         (i_RX_IN),
        .edge_cnt_i   (edge_q),
        .prescale_i   (p_q),
        .rx_s_o       (rx_s),
        .sampled_bit_o(sampled_bit),
        .sample_done_o(sample_done)
    );

    always_comb begin
        case (i_Prescale)
            PRESCALE_W'(PRESCALE_8),
            PRESCALE_W'(PRESCALE_16),
            PRESCALE_W'(PRESCALE_32): presc_legal = i_Prescale;
            default:                  presc_legal = PRESCALE_W'(PRESCALE_DEFAULT);
        endcase
    end

    assign edge_last = (edge_q == p_q - PRESCALE_W'(1));
    assign exp_par   = (i_PAR_TYP == PAR_ODD) ? ~(^shift_q) : (^shift_q);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            edge_q    <= '0;
            p_q       <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
            rx_prev_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            edge_q    <= edge_d;
            p_q       <= p_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            par_err_q <= par_err_d;
            stp_err_q <= stp_err_d;
            rx_prev_q <= rx_s;
        end
    end

    always_comb begin
        state_d   = state_q;
        edge_d    = edge_q;
        p_d       = p_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        par_err_d = par_err_q;
        stp_err_d = stp_err_q;

        unique case (state_q)
            ST_IDLE: begin
                edge_d = '0;
                // Falling edge only, so a held-low line (break) cannot re-trigger.
                if (rx_prev_q && !rx_s) begin
                    state_d   = ST_START;
                    p_d       = presc_legal;
                    par_err_d = 1'b0;
                    stp_err_d = 1'b0;
                end
            end
            ST_START: begin
                edge_d = edge_q + PRESCALE_W'(1);
                if (sample_done && sampled_bit) begin
                    state_d = ST_IDLE;
                    edge_d  = '0;
                end else if (edge_last) begin
                    state_d = ST_DATA;
                    edge_d  = '0;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                edge_d = edge_q + PRESCALE_W'(1);
                if (sample_done) shift_d = {sampled_bit, shift_q[DATA_W-1:1]};
                if (edge_last) begin
                    edge_d = '0;
                    if (bit_q == BIT_W'(DATA_W - 1)) begin
                        bit_d   = '0;
                        state_d = i_PAR_EN ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                edge_d = edge_q + PRESCALE_W'(1);
                if (sample_done && (sampled_bit != exp_par)) par_err_d = 1'b1;
                if (edge_last) begin
                    state_d = ST_STOP;
                    edge_d  = '0;
                end
            end
            ST_STOP: begin
                edge_d = edge_q + PRESCALE_W'(1);
                if (sample_done) begin
                    stp_err_d = stp_err_q | ~sampled_bit;
                    if (!par_err_q && !stp_err_q && sampled_bit) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                    edge_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                edge_d  = '0;
            end
        endcase
    end

    assign o_P_DATA     = data_q;
    assign o_data_valid = valid_q;
    assign o_par_err    = par_err_q;
    assign o_stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: directed frames plus randomized frames against a frame-level model.
module tb_uart_rx_frame;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       par_en;
    logic       par_typ;
    logic [5:0] presc;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_start = 0;
    int         got_cyc = -1;
    logic [7:0] got_q[$];
    logic [7:0] exp_data = 8'h00;

    uart_rx_frame #(
        .DATA_W     (8),
        .PRESCALE_W (6),
        .SYNC_STAGES(2)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_RX_IN     (rx),
        .i_PAR_EN    (par_en),
        .i_PAR_TYP   (par_typ),
        .i_Prescale  (presc),
        .o_P_DATA    (p_data),
        .o_data_valid(data_valid),
        .o_par_err   (par_err),
        .o_stp_err   (stp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid) begin
            got_q.push_back(p_data);
            if (got_cyc < 0) got_cyc = cyc;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned legal_p(input int unsigned v);
        return (v == 8 || v == 16 || v == 32) ? v : 16;
    endfunction

    task automatic drive_bit(input logic b, input int unsigned p);
        repeat (p) begin
            @(negedge clk);
            rx = b;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int unsigned p, input bit pe,
                              input logic pbit, input logic sbit, input bit scramble);
        @(negedge clk);
        last_start = cyc;
        rx = 1'b0;
        repeat (p - 1) @(negedge clk);
        check_eq("flags_clear_at_start", {30'd0, par_err, stp_err}, 32'd0);
        if (scramble) presc = 6'($urandom_range(0, 63));
        for (int i = 0; i < 8; i++) drive_bit(d[i], p);
        if (pe) drive_bit(pbit, p);
        drive_bit(sbit, p);
    endtask

    task automatic idle_gap(input int unsigned n);
        @(negedge clk);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] d, input int unsigned pres_in,
                             input bit pe, input bit typ, input bit bad_par, input bit bad_stop,
                             input bit scramble);
        int unsigned p, lat;
        int          diff;
        bit          good;
        logic        pbit;
        p    = legal_p(pres_in);
        pbit = (^d) ^ typ ^ bad_par;
        good = !(pe && bad_par) && !bad_stop;
        got_q.delete();
        got_cyc = -1;
        @(negedge clk);
        presc   = 6'(pres_in);
        par_en  = pe;
        par_typ = typ;
        send_frame(d, p, pe, pbit, !bad_stop, scramble);
        idle_gap(p + 8);
        if (good) exp_data = d;
        check_eq($sformatf("%s_valid_cnt", tag), got_q.size(), {31'd0, good});
        if (good && got_q.size() > 0) begin
            check_eq($sformatf("%s_valid_data", tag), {24'd0, got_q[0]}, {24'd0, d});
            lat  = 2 + (9 + (pe ? 1 : 0)) * p + p / 2 + 3;
            diff = got_cyc - last_start;
            // Line-edge uncertainty allows one cycle either way.
            check_eq($sformatf("%s_latency", tag),
                     (diff >= int'(lat) - 1 && diff <= int'(lat) + 1) ? lat : diff, lat);
        end
        check_eq($sformatf("%s_pdata", tag), {24'd0, p_data}, {24'd0, exp_data});
        check_eq($sformatf("%s_par_err", tag), {31'd0, par_err}, {31'd0, pe && bad_par});
        check_eq($sformatf("%s_stp_err", tag), {31'd0, stp_err}, {31'd0, bad_stop});
    endtask

    initial begin
        rst     = 1'b1;
        rx      = 1'b1;
        par_en  = 1'b0;
        par_typ = 1'b0;
        presc   = 6'd16;
        repeat (3) @(negedge clk);
        check_eq("reset_outputs", {22'd0, p_data, data_valid, par_err, stp_err}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("post_reset_outputs", {22'd0, p_data, data_valid, par_err, stp_err}, 32'd0);

        run_frame("p8_a5", 8'hA5, 8, 1, 0, 0, 0, 0);

        // Back-to-back frames with no idle gap between stop and next start.
        got_q.delete();
        @(negedge clk);
        presc   = 6'd16;
        par_en  = 1'b1;
        par_typ = 1'b1;
        send_frame(8'h3C, 16, 1, 1'b1, 1'b1, 0);
        send_frame(8'h81, 16, 1, 1'b1, 1'b1, 0);
        idle_gap(24);
        exp_data = 8'h81;
        check_eq("b2b_valid_cnt", got_q.size(), 32'd2);
        if (got_q.size() == 2) begin
            check_eq("b2b_first", {24'd0, got_q[0]}, 32'h3C);
            check_eq("b2b_second", {24'd0, got_q[1]}, 32'h81);
        end
        check_eq("b2b_errs", {30'd0, par_err, stp_err}, 32'd0);

        run_frame("p32_par_bad", 8'h07, 32, 1, 0, 1, 0, 0);
        run_frame("p32_par_clear", 8'hC9, 32, 1, 0, 0, 0, 0);
        run_frame("p8_stop_bad", 8'h55, 8, 0, 0, 0, 1, 0);
        run_frame("p8_stop_clear", 8'h2B, 8, 0, 0, 0, 0, 0);

        // Short low glitch must be rejected by the start-bit vote.
        got_q.delete();
        @(negedge clk);
        presc = 6'd16;
        rx    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rx = 1'b1;
        repeat (48) @(negedge clk);
        check_eq("glitch_no_valid", got_q.size(), 32'd0);
        check_eq("glitch_no_errs", {30'd0, par_err, stp_err}, 32'd0);
        run_frame("after_glitch", 8'h12, 16, 0, 0, 0, 0, 0);

        // Reset in the middle of data bit 4.
        got_q.delete();
        @(negedge clk);
        presc  = 6'd16;
        par_en = 1'b0;
        rx     = 1'b0;
        repeat (15) @(negedge clk);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 16);
        drive_bit(1'b1, 8);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("midframe_rst_outputs", {22'd0, p_data, data_valid, par_err, stp_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_data = 8'h00;
        repeat (320) @(negedge clk);
        check_eq("midframe_rst_no_valid", got_q.size(), 32'd0);
        check_eq("midframe_rst_idle_outputs", {22'd0, p_data, data_valid, par_err, stp_err}, 32'd0);
        run_frame("after_rst", 8'h6E, 16, 0, 0, 0, 0, 0);

        // Break: line low well beyond a frame, then released.
        got_q.delete();
        @(negedge clk);
        presc  = 6'd8;
        par_en = 1'b0;
        drive_bit(1'b0, 8 * 13);
        idle_gap(96);
        check_eq("break_no_valid", got_q.size(), 32'd0);
        check_eq("break_stp_err", {31'd0, stp_err}, 32'd1);
        check_eq("break_par_err", {31'd0, par_err}, 32'd0);
        check_eq("break_pdata", {24'd0, p_data}, {24'd0, exp_data});

        for (int n = 0; n < 24; n++) begin
            int unsigned sel, pres_in;
            sel = $urandom_range(0, 3);
            if (sel == 0)      pres_in = 8;
            else if (sel == 1) pres_in = 16;
            else if (sel == 2) pres_in = 32;
            else begin
                pres_in = $urandom_range(0, 63);
                if (pres_in == 8 || pres_in == 32) pres_in = 5;
            end
            run_frame($sformatf("rnd%0d", n), 8'($urandom), pres_in,
                      1'($urandom), 1'($urandom),
                      ($urandom_range(0, 6) == 0), ($urandom_range(0, 6) == 0),
                      1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
